// File: rtl/fetch_unit.sv
// fetch_unit
//   Fetch stage for the ARM core. Owns the PC, drives the instruction memory
//   address combinationally from it, and captures each returned word together
//   with its PC into a small in-order FIFO. Instructions are handed to decode
//   over a valid/ready handshake. A branch redirect flushes every queued fetch
//   and reloads the PC in one cycle.
//
// Parameters
//   RESET_PC  PC loaded on reset (low two bits forced to zero)
//   DEPTH     FIFO entries, power of two in the range 2..8
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   imem_addr      byte address to instruction memory (always the PC)
//   imem_rd        instruction word returned for imem_addr in the same cycle
//   branch_valid   redirect request
//   branch_target  redirect byte address (bits [1:0] ignored)
//   dec_valid      FIFO head holds a valid instruction
//   dec_ready      decode accepts the head this cycle
//   dec_instr      head instruction word, 0 when dec_valid is low
//   dec_pc         head instruction address, 0 when dec_valid is low
//   dec_pc_plus8   dec_pc + 8 (ARM PC read value), 0 when dec_valid is low

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus8
);

  localparam int              PTR_W            = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT       = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]     WORD_MASK        = 32'hFFFF_FFFC;
  localparam logic [31:0]     RESET_PC_ALIGNED = RESET_PC & WORD_MASK;

  logic [31:0]      pc;
  logic [31:0]      fifo_pc    [DEPTH];
  logic [31:0]      fifo_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic head_valid;
  logic pop;
  logic push;

  assign imem_addr  = pc;
  assign head_valid = (count != '0);

  // A branch cancels both sides of the handshake: the head shown during a
  // redirect cycle is discarded by the flush rather than consumed, and the
  // word arriving on imem_rd belongs to the wrong path.
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // when decode is draining it.
  assign pop  = head_valid & dec_ready & ~branch_valid;
  assign push = ~branch_valid & ((count != FULL_COUNT) | (head_valid & dec_ready));

  // PC, pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two; count carries one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC_ALIGNED;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_valid) begin
      pc     <= branch_target & WORD_MASK;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset: stale contents are never visible because
  // the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= imem_rd;
    end
  end

  // Decode sees the registered head only; dec_ready never reaches these
  // outputs combinationally.
  assign dec_valid    = head_valid;
  assign dec_instr    = head_valid ? fifo_instr[rd_ptr] : 32'd0;
  assign dec_pc       = head_valid ? fifo_pc[rd_ptr] : 32'd0;
  assign dec_pc_plus8 = head_valid ? (fifo_pc[rd_ptr] + 32'd8) : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives two fetch_unit instances (reset PC 0 and reset PC 0xFFFFFFFC) with
//   the same control inputs, each with its own instruction memory model, and
//   compares every output each cycle against a queue-based reference model.
//   A directed prologue pins the model with hand-computed values, then a long
//   randomized run exercises branches, resets and decode back-pressure.

module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC0  = 32'h0000_0000;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        dec_ready;

  logic [31:0] imem_addr0, imem_rd0, dec_instr0, dec_pc0, dec_pc_plus8_0;
  logic        dec_valid0;
  logic [31:0] imem_addr1, imem_rd1, dec_instr1, dec_pc1, dec_pc_plus8_1;
  logic        dec_valid1;

  int checks = 0;
  int errors = 0;

  // Reference model state: fetch PC and an ordered list of queued fetches
  // (index 0 is the head) per instance.
  logic [31:0] m_pc   [2];
  logic [31:0] m_qpc  [2][DEPTH];
  logic [31:0] m_qins [2][DEPTH];
  int          m_cnt  [2];

  logic [31:0] prog_words [4];

  // Instruction memory: the four program words at 0x0..0xC, and a distinct
  // address-derived word everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'hE202_2000;
      32'h4:   return 32'hE382_3005;
      32'h8:   return 32'hE383_4005;
      32'hC:   return 32'hE022_2004;
      default: return addr ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign imem_rd0 = mem_word(imem_addr0);
  assign imem_rd1 = mem_word(imem_addr1);

  fetch_unit #(.RESET_PC(RPC0), .DEPTH(DEPTH)) dut0 (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr0),
    .imem_rd       (imem_rd0),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .dec_valid     (dec_valid0),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr0),
    .dec_pc        (dec_pc0),
    .dec_pc_plus8  (dec_pc_plus8_0)
  );

  fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr1),
    .imem_rd       (imem_rd1),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .dec_valid     (dec_valid1),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr1),
    .dec_pc        (dec_pc1),
    .dec_pc_plus8  (dec_pc_plus8_1)
  );

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance one instance of the model by one clock edge.
  task automatic modelStep(input int i, input logic rst, input logic bv,
                           input logic [31:0] bt, input logic rdy);
    logic do_pop;
    logic do_push;
    if (rst) begin
      m_pc[i]  = (i == 0) ? RPC0 : RPC1;
      m_cnt[i] = 0;
    end else if (bv) begin
      m_pc[i]  = {bt[31:2], 2'b00};
      m_cnt[i] = 0;
    end else begin
      do_pop  = (m_cnt[i] > 0) && rdy;
      do_push = (m_cnt[i] < DEPTH) || do_pop;
      if (do_pop) begin
        for (int k = 0; k < DEPTH - 1; k++) begin
          m_qpc[i][k]  = m_qpc[i][k+1];
          m_qins[i][k] = m_qins[i][k+1];
        end
        m_cnt[i]--;
      end
      if (do_push) begin
        m_qpc[i][m_cnt[i]]  = m_pc[i];
        m_qins[i][m_cnt[i]] = mem_word(m_pc[i]);
        m_cnt[i]++;
        m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic compareDut(input string tag, input int i,
                            input logic [31:0] addr, input logic valid,
                            input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] pc8);
    logic        ev;
    logic [31:0] epc;
    ev  = (m_cnt[i] > 0);
    epc = ev ? m_qpc[i][0] : 32'd0;
    compareValue({tag, ".imem_addr"},    addr,          m_pc[i]);
    compareValue({tag, ".dec_valid"},    {31'd0, valid}, {31'd0, ev});
    compareValue({tag, ".dec_instr"},    instr,         ev ? m_qins[i][0] : 32'd0);
    compareValue({tag, ".dec_pc"},       pc,            epc);
    compareValue({tag, ".dec_pc_plus8"}, pc8,           ev ? epc + 32'd8 : 32'd0);
  endtask

  task automatic checkOutput();
    compareDut("dut0", 0, imem_addr0, dec_valid0, dec_instr0, dec_pc0, dec_pc_plus8_0);
    compareDut("dut1", 1, imem_addr1, dec_valid1, dec_instr1, dec_pc1, dec_pc_plus8_1);
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then compare on the following falling edge.
  task automatic applyStimulus(input logic rst, input logic bv,
                               input logic [31:0] bt, input logic rdy);
    reset         = rst;
    branch_valid  = bv;
    branch_target = bt;
    dec_ready     = rdy;
    modelStep(0, rst, bv, bt, rdy);
    modelStep(1, rst, bv, bt, rdy);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [31:0] tgt;
    logic        r_rst;
    logic        r_bv;
    logic        r_rdy;

    prog_words[0] = 32'hE202_2000;
    prog_words[1] = 32'hE382_3005;
    prog_words[2] = 32'hE383_4005;
    prog_words[3] = 32'hE022_2004;

    // Reset held for three cycles.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      compareValue("rst.addr0",  imem_addr0, 32'h0);
      compareValue("rst.valid0", {31'd0, dec_valid0}, 32'd0);
      compareValue("rst.addr1",  imem_addr1, 32'hFFFF_FFFC);
    end

    // First edge after release.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    compareValue("first.valid0", {31'd0, dec_valid0}, 32'd1);
    compareValue("first.instr0", dec_instr0, 32'hE202_2000);
    compareValue("first.pc0",    dec_pc0, 32'h0);
    compareValue("first.pc8_0",  dec_pc_plus8_0, 32'h8);
    compareValue("first.addr0",  imem_addr0, 32'h4);
    compareValue("first.pc1",    dec_pc1, 32'hFFFF_FFFC);

    // Back-pressure: five more stalled cycles fill the FIFO.
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    compareValue("stall.addr0", imem_addr0, 32'h8);
    compareValue("stall.pc0",   dec_pc0, 32'h0);

    // Full FIFO with decode ready: pop pc 0 and push pc 8 on the same edge.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    compareValue("pushpop.pc0",    dec_pc0, 32'h4);
    compareValue("pushpop.instr0", dec_instr0, 32'hE382_3005);
    compareValue("pushpop.addr0",  imem_addr0, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    compareValue("stillfull.addr0", imem_addr0, 32'hC);

    // Branch to 0x7 while full with decode ready.
    applyStimulus(1'b0, 1'b1, 32'h0000_0007, 1'b1);
    compareValue("br.valid0", {31'd0, dec_valid0}, 32'd0);
    compareValue("br.addr0",  imem_addr0, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    compareValue("br.pc0",    dec_pc0, 32'h4);
    compareValue("br.instr0", dec_instr0, 32'hE382_3005);

    // Fill again, then reset while full.
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    compareValue("rstfull.valid1", {31'd0, dec_valid1}, 32'd0);
    compareValue("rstfull.addr1",  imem_addr1, 32'hFFFF_FFFC);
    compareValue("rstfull.addr0",  imem_addr0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);

    // Streaming with decode always ready: one instruction per cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      compareValue("stream.pc0",    dec_pc0, 32'(k * 4));
      compareValue("stream.instr0", dec_instr0, prog_words[k]);
      if (k == 0) compareValue("stream.pc1_first",  dec_pc1, 32'hFFFF_FFFC);
      if (k == 1) compareValue("stream.pc1_second", dec_pc1, 32'h0);
    end

    // Randomized run: occasional resets, frequent branches (including near
    // the program words and the top of the address space), random ready.
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_bv  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       tgt = 32'($urandom_range(0, 15));
        1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: tgt = $urandom;
      endcase
      applyStimulus(r_rst, r_bv, tgt, r_rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
